// File: rtl/db_hash_engine_if.sv
// Request/response bundle for db_hash_engine.
// master drives requests, slave is the engine.
interface db_hash_engine_if #(
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32,
  parameter int HASH_SIZE = 32,
  parameter int FLAG_SIZE = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FLAG_SIZE-1:0] in_op;
  logic [HASH_SIZE-1:0] in_hash;
  logic [KEY_SIZE-1:0]  in_key;
  logic [VAL_SIZE-1:0]  in_value;
  logic                 tick;
  logic                 out_valid;
  logic [FLAG_SIZE-1:0] out_flag;
  logic [VAL_SIZE-1:0]  out_value;

  modport master (
    output in_valid, in_op, in_hash, in_key, in_value, tick,
    input  in_ready, out_valid, out_flag, out_value
  );

  modport slave (
    input  in_valid, in_op, in_hash, in_key, in_value, tick,
    output in_ready, out_valid, out_flag, out_value
  );
endinterface

// File: rtl/db_hash_engine.sv
// WAYS-way set-associative key/value table: LOOKUP/INSERT/DELETE.
// Optional entry aging under `define DB_AGING_EN.
module db_hash_engine #(
  parameter int          KEY_SIZE  = 96,
  parameter int          VAL_SIZE  = 32,
  parameter int          HASH_SIZE = 32,
  parameter int          FLAG_SIZE = 4,
  parameter int          IDX_BITS  = 10,
  parameter int          WAYS      = 2,
  parameter logic [15:0] AGE_LIMIT = 16'd1000
) (
  input logic           clk,
  input logic           rst,
  db_hash_engine_if.slave bus
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [FLAG_SIZE-1:0] flag_t;
  typedef logic [WAY_W-1:0] way_t;

  localparam flag_t OP_LOOKUP   = flag_t'(1);
  localparam flag_t OP_INSERT   = flag_t'(2);
  localparam flag_t OP_DELETE   = flag_t'(3);
  localparam flag_t ST_MISS     = flag_t'(0);
  localparam flag_t ST_HIT      = flag_t'(1);
  localparam flag_t ST_INSERTED = flag_t'(2);
  localparam flag_t ST_UPDATED  = flag_t'(3);
  localparam flag_t ST_EVICTED  = flag_t'(4);
  localparam flag_t ST_DELETED  = flag_t'(5);
  localparam flag_t ST_EXPIRED  = flag_t'(6);
  localparam flag_t ST_BADOP    = flag_t'(15);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_RESP} state_t;

  state_t                     state_q, state_d;
  flag_t                      op_q, op_d;
  logic [KEY_SIZE-1:0]        key_q, key_d;
  logic [VAL_SIZE-1:0]        val_q, val_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic [DEPTH-1:0][WAYS-1:0] vld_q, vld_d;
  logic [WAYS-1:0]            rd_vld_q, rd_vld_d;
  way_t                       victim_q, victim_d;
  flag_t                      res_flag_q, res_flag_d;
  logic [VAL_SIZE-1:0]        res_val_q, res_val_d;
  logic                       out_valid_q, out_valid_d;
  flag_t                      out_flag_q, out_flag_d;
  logic [VAL_SIZE-1:0]        out_value_q, out_value_d;

  logic [KEY_SIZE-1:0] key_mem [WAYS][DEPTH];
  logic [VAL_SIZE-1:0] val_mem [WAYS][DEPTH];
  logic [KEY_SIZE-1:0] rd_key_q [WAYS];
  logic [VAL_SIZE-1:0] rd_val_q [WAYS];

  logic wr_en;
  way_t wr_way;
  logic hit, hit_exp, free;
  way_t hit_way, free_way;

`ifdef DB_AGING_EN
  logic [15:0] now_q, now_d;
  logic [15:0] ts_mem [WAYS][DEPTH];
  logic [15:0] rd_ts_q [WAYS];
  logic [15:0] age;

  always_comb now_d = now_q + 16'(bus.tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) now_q <= '0;
    else     now_q <= now_d;
  end
`endif

  // Descending scan so the lowest-numbered way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_vld_q[w] && rd_key_q[w] == key_q) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
      if (!rd_vld_q[w]) begin
        free     = 1'b1;
        free_way = way_t'(w);
      end
    end
`ifdef DB_AGING_EN
    age     = now_q - rd_ts_q[hit_way];
    hit_exp = hit && (age > AGE_LIMIT);
`else
    hit_exp = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    idx_d       = idx_q;
    vld_d       = vld_q;
    rd_vld_d    = rd_vld_q;
    victim_d    = victim_q;
    res_flag_d  = res_flag_q;
    res_val_d   = res_val_q;
    out_valid_d = 1'b0;
    out_flag_d  = '0;
    out_value_d = '0;
    wr_en       = 1'b0;
    wr_way      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          key_d   = bus.in_key;
          val_d   = bus.in_value;
          idx_d   = bus.in_hash[IDX_BITS-1:0];
          state_d = S_READ;
        end
      end
      S_READ: begin
        rd_vld_d = vld_q[idx_q];
        state_d  = S_CMP;
      end
      S_CMP: begin
        state_d   = S_RESP;
        res_val_d = '0;
        if (hit_exp) vld_d[idx_q][hit_way] = 1'b0;
        case (op_q)
          OP_LOOKUP: begin
            if (hit && !hit_exp) begin
              res_flag_d = ST_HIT;
              res_val_d  = rd_val_q[hit_way];
            end else begin
              res_flag_d = hit ? ST_EXPIRED : ST_MISS;
            end
          end
          OP_INSERT: begin
            wr_en      = 1'b1;
            res_flag_d = ST_INSERTED;
            if (hit) begin
              wr_way = hit_way;
              if (!hit_exp) res_flag_d = ST_UPDATED;
            end else if (free) begin
              wr_way = free_way;
            end else begin
              wr_way     = victim_q;
              res_flag_d = ST_EVICTED;
              victim_d   = (victim_q == way_t'(WAYS - 1)) ?
                           '0 : victim_q + 1'b1;
            end
            vld_d[idx_q][wr_way] = 1'b1;
          end
          OP_DELETE: begin
            if (hit) begin
              vld_d[idx_q][hit_way] = 1'b0;
              res_flag_d = hit_exp ? ST_EXPIRED : ST_DELETED;
            end else begin
              res_flag_d = ST_MISS;
            end
          end
          default: res_flag_d = ST_BADOP;
        endcase
      end
      S_RESP: begin
        out_valid_d = 1'b1;
        out_flag_d  = res_flag_q;
        out_value_d = res_val_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      key_q       <= '0;
      val_q       <= '0;
      idx_q       <= '0;
      vld_q       <= '0;
      rd_vld_q    <= '0;
      victim_q    <= '0;
      res_flag_q  <= '0;
      res_val_q   <= '0;
      out_valid_q <= 1'b0;
      out_flag_q  <= '0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      val_q       <= val_d;
      idx_q       <= idx_d;
      vld_q       <= vld_d;
      rd_vld_q    <= rd_vld_d;
      victim_q    <= victim_d;
      res_flag_q  <= res_flag_d;
      res_val_q   <= res_val_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_value_q <= out_value_d;
    end
  end

  // Table storage is not reset.
  always_ff @(posedge clk) begin
    if (state_q == S_READ) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_key_q[w] <= key_mem[w][idx_q];
        rd_val_q[w] <= val_mem[w][idx_q];
`ifdef DB_AGING_EN
        rd_ts_q[w]  <= ts_mem[w][idx_q];
`endif
      end
    end
    if (wr_en) begin
      key_mem[wr_way][idx_q] <= key_q;
      val_mem[wr_way][idx_q] <= val_q;
`ifdef DB_AGING_EN
      ts_mem[wr_way][idx_q]  <= now_q;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_flag  = out_flag_q;
  assign bus.out_value = out_value_q;
endmodule

// File: doc/db_hash_engine.md
Name: db_hash_engine

Overview:
Parametrised hash-indexed key/value table engine for the filtering datapath. It replaces the single-way database controller with a WAYS-way set-associative table held in on-chip storage. It serves LOOKUP, INSERT and DELETE requests from the network side. The bucket index comes from the upstream CRC32 hash, and each request returns a one-cycle response with a status flag and value.

Parameters:
KEY_SIZE, 96, key width in bits (src IP, dst IP, dst UDP port, reserved).
VAL_SIZE, 32, value width in bits.
HASH_SIZE, 32, width of the incoming hash.
FLAG_SIZE, 4, op/status code width.
IDX_BITS, 10, bucket index width; table depth is 2^IDX_BITS buckets.
WAYS, 2, entries per bucket; legal range 1..8.
AGE_LIMIT, 16'd1000, maximum entry age in ticks; used only with DB_AGING_EN.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  request strobe.
in_ready  out  1  engine can accept a request.
in_op  in  FLAG_SIZE  1=LOOKUP, 2=INSERT, 3=DELETE.
in_hash  in  HASH_SIZE  hash of in_key.
in_key  in  KEY_SIZE  request key.
in_value  in  VAL_SIZE  value for INSERT.
tick  in  1  aging time-base pulse.
out_valid  out  1  response strobe, one cycle.
out_flag  out  FLAG_SIZE  response status.
out_value  out  VAL_SIZE  value on HIT, otherwise 0.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_flag=0, out_value=0, FSM=IDLE, all per-entry valid bits=0, victim pointer=0. Key/value storage is not reset.
- Bucket index: in_hash[IDX_BITS-1:0].
- Handshake: a request is accepted when in_valid && in_ready. in_ready is high only in IDLE; there is no response backpressure.
- FSM: IDLE -> READ -> CMP -> RESP -> IDLE.
  - IDLE: on accept, register op/key/value/index.
  - READ: synchronous read of all WAYS entries of the bucket.
  - CMP: parallel compare of valid && key==stored key; select the lowest matching way; perform any write at the CMP->RESP edge.
  - RESP: out_valid=1 for exactly one cycle.
- Latency: accept at edge T, out_valid high in the cycle after edge T+3. Throughput is one request per 4 cycles; in_ready returns high in the cycle after RESP.
- Status codes:
  - 0 MISS, 1 HIT, 2 INSERTED, 3 UPDATED, 4 EVICTED, 5 DELETED, 6 EXPIRED, 15 BADOP.
- LOOKUP: hit -> HIT plus stored value; no match -> MISS, out_value=0.
- INSERT:
  - Key match -> overwrite value, UPDATED.
  - Otherwise the lowest-numbered invalid way takes the entry -> INSERTED.
  - Bucket full -> overwrite way victim_ptr -> EVICTED; victim_ptr then increments modulo WAYS. It is a single global pointer.
- DELETE: match -> clear valid bit, DELETED; no match -> MISS, no write.
- Any other op (including 0): BADOP with the same 4-cycle latency and no table change.
- Duplicate keys cannot exist: UPDATED takes priority over inserting into a free way.
- Reset asserted mid-operation aborts the request with no response; a partial write does not occur because all writes happen on a single edge.

Optional Feature:
DB_AGING_EN.
- Defined:
  - A 16-bit now counter resets to 0 and increments on each cycle with tick=1, wrapping modulo 2^16.
  - Each entry stores a 16-bit timestamp, written with now on INSERTED, UPDATED and EVICTED.
  - In CMP, a matching entry with (now - ts) mod 2^16 > AGE_LIMIT is expired: its valid bit is cleared.
  - For an expired match, LOOKUP and DELETE return EXPIRED with out_value=0.
  - For an expired match, INSERT reuses that way, writes the new entry and returns INSERTED.
- Undefined: no timestamp storage, tick is ignored, code 6 is never produced.

Test Plan:
- INSERT key K1=96'h0A000001_0A000002_0035_0000, hash 0x5, value 0x1234ABCD -> INSERTED. Then LOOKUP K1 -> HIT, 0x1234ABCD, out_valid exactly 4 cycles after accept.
- INSERT K1 with value 0xDEADBEEF -> UPDATED. LOOKUP -> 0xDEADBEEF.
- WAYS=2: INSERT K1, K2, K3, all with hash 0x5 -> INSERTED, INSERTED, EVICTED. LOOKUP K1 -> MISS; LOOKUP K3 -> HIT.
- DELETE K2 -> DELETED; DELETE K2 again -> MISS. in_op=7 -> BADOP, table unchanged.
- Hold in_valid high continuously -> accepts spaced 4 cycles apart. Assert rst during READ -> no out_valid, in_ready=1 next cycle, all lookups MISS.
- DB_AGING_EN, AGE_LIMIT=3:
  - INSERT K1, then 4 tick pulses, LOOKUP K1 -> EXPIRED.
  - Repeat the LOOKUP -> MISS.
  - INSERT K1 after 3 ticks, LOOKUP -> HIT.
